// File: rtl/spi_slave_regs_if.sv
// SPI bus bundle for spi_slave_regs: master drives ss/sclk/mosi, slave returns miso.
interface spi_slave_regs_if;
    logic ss;
    logic sclk;
    logic mosi;
    logic miso;

    modport master (output ss, output sclk, output mosi, input miso);
    modport slave  (input ss, input sclk, input mosi, output miso);
endinterface

// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave with a 16 x 8 register file; 24-bit frames of ID, address, data.
// state   | meaning
// IDLE    | waiting for ss to fall
// ID      | shifting in the ID byte
// ADDR    | shifting in the address byte
// DATA    | shifting data in (write) or out on miso (read)
// WAIT_SS | frame done or rejected, ignoring sclk until ss rises
module spi_slave_regs #(
    parameter logic [7:0] SLAVE_IDW = 8'hFF,
    parameter logic [7:0] SLAVE_IDR = 8'h00
) (
    input  logic               clock,
    input  logic               reset,
    spi_slave_regs_if.slave    spi,
    input  logic [3:0]         loc_addr,
    output logic [7:0]         loc_rdata,
    output logic               wr_pulse,
    output logic [7:0]         wr_addr,
    output logic [7:0]         wr_data,
    output logic               frame_err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ID      = 3'd1;
    localparam logic [2:0] ADDR    = 3'd2;
    localparam logic [2:0] DATA    = 3'd3;
    localparam logic [2:0] WAIT_SS = 3'd4;

    logic [1:0] ss_sync, sclk_sync, mosi_sync;
    logic       ss_q, sclk_q;
    logic [2:0] state;
    logic [4:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] addr_reg;
    logic [7:0] rd_shift;
    logic       is_write;
    logic [7:0] regs [16];

    logic       ss_s, sclk_s, mosi_s;
    logic       ss_rise, ss_fall, sclk_rise, sclk_fall;
    logic [7:0] shift_nxt;
    logic [4:0] cnt_nxt;

    assign ss_s      = ss_sync[1];
    assign sclk_s    = sclk_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign ss_rise   = ss_s & ~ss_q;
    assign ss_fall   = ~ss_s & ss_q;
    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign shift_nxt = {shift_reg[6:0], mosi_s};
    // Saturate so stray sclk edges past bit 24 can never look like a new frame.
    assign cnt_nxt   = (bit_cnt == 5'd24) ? 5'd24 : bit_cnt + 5'd1;

    assign spi.miso  = (state == DATA && !is_write) ? rd_shift[7] : 1'b0;

    always_ff @(posedge clock) begin
        if (reset) begin
            ss_sync   <= 2'b11;
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            ss_q      <= 1'b1;
            sclk_q    <= 1'b0;
        end else begin
            ss_sync   <= {ss_sync[0], spi.ss};
            sclk_sync <= {sclk_sync[0], spi.sclk};
            mosi_sync <= {mosi_sync[0], spi.mosi};
            ss_q      <= ss_s;
            sclk_q    <= sclk_s;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= 5'd0;
            shift_reg <= 8'h00;
            addr_reg  <= 8'h00;
            rd_shift  <= 8'h00;
            is_write  <= 1'b0;
            loc_rdata <= 8'h00;
            wr_pulse  <= 1'b0;
            wr_addr   <= 8'h00;
            wr_data   <= 8'h00;
            frame_err <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
        end else begin
            wr_pulse  <= 1'b0;
            frame_err <= 1'b0;
            loc_rdata <= regs[loc_addr];
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state     <= ID;
                        bit_cnt   <= 5'd0;
                        shift_reg <= 8'h00;
                    end
                end
                ID, ADDR, DATA: begin
                    if (ss_rise) begin
                        state     <= IDLE;
                        frame_err <= 1'b1;
                    end else if (sclk_rise) begin
                        shift_reg <= shift_nxt;
                        bit_cnt   <= cnt_nxt;
                        if (state == ID && cnt_nxt == 5'd8) begin
                            if (shift_nxt == SLAVE_IDW) begin
                                is_write <= 1'b1;
                                state    <= ADDR;
                            end else if (shift_nxt == SLAVE_IDR) begin
                                is_write <= 1'b0;
                                state    <= ADDR;
                            end else begin
                                state     <= WAIT_SS;
                                frame_err <= 1'b1;
                            end
                        end else if (state == ADDR && cnt_nxt == 5'd16) begin
                            addr_reg <= shift_nxt;
                            rd_shift <= 8'h00;
                            state    <= DATA;
                        end else if (state == DATA && cnt_nxt == 5'd24) begin
                            state <= WAIT_SS;
                            if (is_write) begin
                                wr_pulse <= 1'b1;
                                wr_addr  <= addr_reg;
                                wr_data  <= shift_nxt;
                                if (addr_reg[7:4] == 4'h0) regs[addr_reg[3:0]] <= shift_nxt;
                            end
                        end
                    end else if (sclk_fall && state == DATA && !is_write) begin
                        if (bit_cnt == 5'd16)
                            rd_shift <= (addr_reg[7:4] == 4'h0) ? regs[addr_reg[3:0]] : 8'h00;
                        else
                            rd_shift <= {rd_shift[6:0], 1'b0};
                    end
                end
                WAIT_SS: begin
                    if (ss_rise) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Self-checking bench for spi_slave_regs: directed scenarios plus random frames vs. a register-array model.
module tb_spi_slave_regs;
    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] loc_addr;
    logic [7:0] loc_rdata, wr_addr, wr_data;
    logic       wr_pulse, frame_err;

    always #5 clock = ~clock;

    spi_slave_regs_if spi ();

    spi_slave_regs #(.SLAVE_IDW(8'hFF), .SLAVE_IDR(8'h00)) dut (
        .clock     (clock),
        .reset     (reset),
        .spi       (spi.slave),
        .loc_addr  (loc_addr),
        .loc_rdata (loc_rdata),
        .wr_pulse  (wr_pulse),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    int         vectors = 0;
    int         errors  = 0;
    logic [7:0] model_regs [16];

    // Strobe monitor: counts pulses and captures what came with them.
    int         wr_cnt = 0;
    int         ferr_cnt = 0;
    logic [7:0] mon_addr, mon_data, rd_at, rd_after;
    logic       wr_d = 1'b0;
    always @(negedge clock) begin
        if (wr_pulse === 1'b1) begin
            wr_cnt   <= wr_cnt + 1;
            mon_addr <= wr_addr;
            mon_data <= wr_data;
            rd_at    <= loc_rdata;
        end
        if (wr_d) rd_after <= loc_rdata;
        wr_d <= (wr_pulse === 1'b1);
        if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Drives nbits sclk pulses of {id,a,d} (random filler past bit 24); ss left low.
    task automatic spi_xfer(input logic [7:0] id, input logic [7:0] a, input logic [7:0] d,
                            input int half, input int nbits,
                            output logic [7:0] rx, output logic miso_bad);
        logic [23:0] fr;
        fr = {id, a, d};
        rx = 8'h00;
        miso_bad = 1'b0;
        spi.ss = 1'b0;
        wait_clk(half);
        for (int i = 0; i < nbits; i++) begin
            spi.mosi = (i < 24) ? fr[23-i] : 1'($urandom_range(0, 1));
            wait_clk(half);
            if (i >= 16 && i < 24) rx = {rx[6:0], spi.miso};
            else if (spi.miso !== 1'b0) miso_bad = 1'b1;
            spi.sclk = 1'b1;
            wait_clk(half);
            spi.sclk = 1'b0;
        end
    endtask

    task automatic end_frame(input int half);
        wait_clk(half);
        spi.ss   = 1'b1;
        spi.mosi = 1'b0;
        wait_clk(half + 6);
    endtask

    task automatic do_frame(input logic [7:0] id, input logic [7:0] a, input logic [7:0] d,
                            input int half, input int nbits,
                            output logic [7:0] rx, output logic miso_bad,
                            output int dwr, output int dferr);
        int w0, f0;
        w0 = wr_cnt;
        f0 = ferr_cnt;
        spi_xfer(id, a, d, half, nbits, rx, miso_bad);
        end_frame(half);
        dwr   = wr_cnt - w0;
        dferr = ferr_cnt - f0;
    endtask

    task automatic read_loc(input logic [3:0] a, output logic [7:0] v);
        loc_addr = a;
        wait_clk(2);
        v = loc_rdata;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        reset = 1'b1; spi.ss = 1'b1; spi.sclk = 1'b0; spi.mosi = 1'b0; loc_addr = 4'h0;
        wait_clk(3);
        vectors++; if (spi.miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", spi.miso); end
        vectors++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL reset_wr_pulse got %b want 0", wr_pulse); end
        vectors++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
        vectors++; if (wr_data !== 8'h00) begin errors++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
        vectors++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        vectors++; if (loc_rdata !== 8'h00) begin errors++; $display("FAIL reset_loc_rdata got %h want 00", loc_rdata); end
        reset = 1'b0;
        wait_clk(2);
        for (int i = 0; i < 16; i++) begin
            model_regs[i] = 8'h00;
            read_loc(4'(i), v);
            vectors++; if (v !== 8'h00) begin errors++; $display("FAIL reset_reg%0d got %h want 00", i, v); end
        end
    endtask

    task automatic test_write_readback;
        logic [7:0] rx, v; logic mb; int dwr, dferr;
        do_frame(8'hFF, 8'h05, 8'hA5, 8, 24, rx, mb, dwr, dferr);
        model_regs[5] = 8'hA5;
        vectors++; if (dwr !== 1) begin errors++; $display("FAIL wr_pulse_count got %0d want 1", dwr); end
        vectors++; if (mon_addr !== 8'h05) begin errors++; $display("FAIL wr_addr got %h want 05", mon_addr); end
        vectors++; if (mon_data !== 8'hA5) begin errors++; $display("FAIL wr_data got %h want a5", mon_data); end
        vectors++; if (mb !== 1'b0 || rx !== 8'h00) begin errors++; $display("FAIL wr_miso_quiet got %b/%h want 0/00", mb, rx); end
        read_loc(4'h5, v);
        vectors++; if (v !== 8'hA5) begin errors++; $display("FAIL loc_read5 got %h want a5", v); end
        do_frame(8'h00, 8'h05, 8'h00, 8, 24, rx, mb, dwr, dferr);
        vectors++; if (rx !== 8'hA5) begin errors++; $display("FAIL readback_miso got %h want a5", rx); end
        vectors++; if (dwr !== 0 || dferr !== 0) begin errors++; $display("FAIL readback_strobes got wr=%0d ferr=%0d want 0/0", dwr, dferr); end
        vectors++; if (mb !== 1'b0) begin errors++; $display("FAIL readback_miso_idle got %b want 0", mb); end
    endtask

    task automatic test_out_of_range;
        logic [7:0] rx, v; logic mb; int dwr, dferr;
        do_frame(8'hFF, 8'h20, 8'h3C, 6, 24, rx, mb, dwr, dferr);
        vectors++; if (dwr !== 1 || mon_addr !== 8'h20 || mon_data !== 8'h3C) begin
            errors++; $display("FAIL oor_write got n=%0d a=%h d=%h want 1/20/3c", dwr, mon_addr, mon_data); end
        for (int i = 0; i < 16; i++) begin
            read_loc(4'(i), v);
            vectors++; if (v !== model_regs[i]) begin errors++; $display("FAIL oor_reg%0d got %h want %h", i, v, model_regs[i]); end
        end
        do_frame(8'h00, 8'h20, 8'h00, 6, 24, rx, mb, dwr, dferr);
        vectors++; if (rx !== 8'h00) begin errors++; $display("FAIL oor_read got %h want 00", rx); end
    endtask

    task automatic test_bad_id;
        logic [7:0] rx, v; logic mb; int f0, w0;
        f0 = ferr_cnt; w0 = wr_cnt;
        spi_xfer(8'h5A, 8'h03, 8'h99, 5, 8, rx, mb);
        wait_clk(6);
        vectors++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL badid_ferr_after_bit8 got %0d want 1", ferr_cnt - f0); end
        end_frame(5);
        f0 = ferr_cnt;
        spi_xfer(8'h5A, 8'h03, 8'h99, 5, 24, rx, mb);
        end_frame(5);
        vectors++; if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL badid_ferr_full got %0d want 1", ferr_cnt - f0); end
        vectors++; if (mb !== 1'b0 || rx !== 8'h00) begin errors++; $display("FAIL badid_miso got %b/%h want 0/00", mb, rx); end
        vectors++; if (wr_cnt !== w0) begin errors++; $display("FAIL badid_wr got %0d want 0", wr_cnt - w0); end
        read_loc(4'h3, v);
        vectors++; if (v !== model_regs[3]) begin errors++; $display("FAIL badid_reg3 got %h want %h", v, model_regs[3]); end
    endtask

    task automatic test_abort;
        logic [7:0] rx, v; logic mb; int dwr, dferr;
        do_frame(8'hFF, 8'h01, 8'h42, 4, 24, rx, mb, dwr, dferr);
        model_regs[1] = 8'h42;
        do_frame(8'hFF, 8'h01, 8'hE7, 4, 20, rx, mb, dwr, dferr);
        vectors++; if (dferr !== 1 || dwr !== 0) begin errors++; $display("FAIL abort_strobes got ferr=%0d wr=%0d want 1/0", dferr, dwr); end
        read_loc(4'h1, v);
        vectors++; if (v !== 8'h42) begin errors++; $display("FAIL abort_reg1 got %h want 42", v); end
        do_frame(8'hFF, 8'h01, 8'h5C, 4, 24, rx, mb, dwr, dferr);
        model_regs[1] = 8'h5C;
        read_loc(4'h1, v);
        vectors++; if (dwr !== 1 || dferr !== 0 || v !== 8'h5C) begin
            errors++; $display("FAIL abort_next_frame got wr=%0d ferr=%0d reg=%h want 1/0/5c", dwr, dferr, v); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] rx, v; logic mb; int w0, f0, dwr, dferr;
        w0 = wr_cnt; f0 = ferr_cnt;
        spi_xfer(8'hFF, 8'h03, 8'h11, 6, 12, rx, mb);
        reset = 1'b1;
        spi.ss = 1'b1;
        wait_clk(3);
        vectors++; if ({spi.miso, wr_pulse, frame_err} !== 3'b000 || wr_addr !== 8'h00 || wr_data !== 8'h00 || loc_rdata !== 8'h00) begin
            errors++; $display("FAIL midreset_outputs got miso=%b wp=%b fe=%b wa=%h wd=%h rd=%h want all 0",
                               spi.miso, wr_pulse, frame_err, wr_addr, wr_data, loc_rdata); end
        reset = 1'b0;
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
        wait_clk(6);
        vectors++; if (wr_cnt !== w0 || ferr_cnt !== f0) begin
            errors++; $display("FAIL midreset_strobes got wr=%0d ferr=%0d want 0/0", wr_cnt - w0, ferr_cnt - f0); end
        do_frame(8'hFF, 8'h0F, 8'h77, 6, 24, rx, mb, dwr, dferr);
        model_regs[15] = 8'h77;
        read_loc(4'hF, v);
        vectors++; if (dwr !== 1 || v !== 8'h77) begin errors++; $display("FAIL midreset_next got wr=%0d reg=%h want 1/77", dwr, v); end
        read_loc(4'h5, v);
        vectors++; if (v !== 8'h00) begin errors++; $display("FAIL midreset_cleared got %h want 00", v); end
    endtask

    task automatic test_saturate;
        logic [7:0] rx, v; logic mb; int dwr, dferr;
        do_frame(8'hFF, 8'h09, 8'hC3, 4, 34, rx, mb, dwr, dferr);
        model_regs[9] = 8'hC3;
        vectors++; if (dwr !== 1 || dferr !== 0 || mon_data !== 8'hC3) begin
            errors++; $display("FAIL saturate got wr=%0d ferr=%0d d=%h want 1/0/c3", dwr, dferr, mon_data); end
        read_loc(4'h9, v);
        vectors++; if (v !== 8'hC3) begin errors++; $display("FAIL saturate_reg9 got %h want c3", v); end
    endtask

    task automatic test_collision;
        logic [7:0] rx, old_v; logic mb; int dwr, dferr;
        old_v = model_regs[7];
        loc_addr = 4'h7;
        do_frame(8'hFF, 8'h07, 8'h3A, 5, 24, rx, mb, dwr, dferr);
        model_regs[7] = 8'h3A;
        vectors++; if (rd_at !== old_v) begin errors++; $display("FAIL collision_old got %h want %h", rd_at, old_v); end
        vectors++; if (rd_after !== 8'h3A) begin errors++; $display("FAIL collision_new got %h want 3a", rd_after); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] id, a, d, rx, exp_rx, v; logic mb; int kind, half, nbits, dwr, dferr;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            half = $urandom_range(4, 10);
            a    = ($urandom_range(0, 4) == 0) ? {4'($urandom_range(1, 15)), 4'($urandom)} : {4'h0, 4'($urandom)};
            d    = 8'($urandom);
            nbits = 24;
            if (kind <= 4) id = 8'hFF;
            else if (kind <= 7) id = 8'h00;
            else if (kind == 8) begin
                id = 8'($urandom);
                while (id == 8'hFF || id == 8'h00) id = 8'($urandom);
            end else begin
                id = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
                nbits = $urandom_range(1, 23);
            end
            exp_rx = (a[7:4] == 4'h0) ? model_regs[a[3:0]] : 8'h00;
            do_frame(id, a, d, half, nbits, rx, mb, dwr, dferr);
            if (kind <= 4) begin
                vectors++; if (dwr !== 1 || dferr !== 0 || mon_addr !== a || mon_data !== d) begin
                    errors++; $display("FAIL rand%0d_write got n=%0d fe=%0d a=%h d=%h want 1/0/%h/%h", n, dwr, dferr, mon_addr, mon_data, a, d); end
                if (a[7:4] == 4'h0) model_regs[a[3:0]] = d;
            end else if (kind <= 7) begin
                vectors++; if (rx !== exp_rx || dwr !== 0 || dferr !== 0) begin
                    errors++; $display("FAIL rand%0d_read a=%h got %h wr=%0d fe=%0d want %h/0/0", n, a, rx, dwr, dferr, exp_rx); end
            end else begin
                vectors++; if (dferr !== 1 || dwr !== 0) begin
                    errors++; $display("FAIL rand%0d_err kind=%0d nbits=%0d got fe=%0d wr=%0d want 1/0", n, kind, nbits, dferr, dwr); end
            end
            vectors++; if (mb !== 1'b0) begin errors++; $display("FAIL rand%0d_miso_idle got 1 want 0", n); end
        end
        for (int i = 0; i < 16; i++) begin
            read_loc(4'(i), v);
            vectors++; if (v !== model_regs[i]) begin errors++; $display("FAIL final_reg%0d got %h want %h", i, v, model_regs[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_write_readback;
        test_out_of_range;
        test_bad_id;
        test_abort;
        test_reset_mid_frame;
        test_saturate;
        test_collision;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
